encounter_gen: RTL and testbench



---
 rtl/encounter_pkg.sv | 34 +++
 rtl/lfsr16.sv | 23 ++
 rtl/encounter_gen.sv | 157 +++++++++++++++
 tb/tb_encounter_gen.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encounter_pkg.sv
// Shared types and constants for the overworld wild-encounter generator.
// Covers FSM states, display_control codes, movement keycodes and the LFSR mask.
package encounter_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WALK      = 3'd1,
    REQUEST   = 3'd2,
    IN_BATTLE = 3'd3,
    COOLDOWN  = 3'd4
  } state_t;

  localparam logic [1:0] DC_INIT   = 2'b00;
  localparam logic [1:0] DC_SELECT = 2'b01;
  localparam logic [1:0] DC_MAP    = 2'b10;
  localparam logic [1:0] DC_BATTLE = 2'b11;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  function automatic logic is_move(input logic [7:0] key);
    return (key == KEY_W) || (key == KEY_A) || (key == KEY_S) || (key == KEY_D);
  endfunction

  // Only three species exist, so the fourth code folds back onto the first.
  function automatic logic [1:0] map_species(input logic [1:0] raw);
    return (raw == 2'd3) ? 2'd0 : raw;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, right-shifting; a zero seed is replaced by 1
// because the all-zero state would lock up.
module lfsr16
  import encounter_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] value
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      value <= SEED_EFF;
    end else begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_MASK : 16'h0000);
    end
  end

endmodule

// File: rtl/encounter_gen.sv
// Wild-encounter generator: counts grass steps, rolls the LFSR per step and holds
// battle_start until the game-state FSM shows the battle screen.
//
// state     | meaning
// IDLE      | not on the map; nothing counted
// WALK      | on the map; each completed grass step rolls for an encounter
// REQUEST   | encounter fired; battle_start held until display shows battle
// IN_BATTLE | battle on screen; latched species/level in use
// COOLDOWN  | back on map; steps counted down with no rolls
module encounter_gen
  import encounter_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED        = 16'hACE1,
  parameter int unsigned STEP_FRAMES      = 8,
  parameter logic [8:0]  ENCOUNTER_THRESH = 9'd24,
  parameter int unsigned COOLDOWN_STEPS   = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       in_grass,
  input  logic [1:0] display_control,
  output logic       battle_start,
  output logic [1:0] wild_species,
  output logic [4:0] wild_level,
  output logic       step_pulse
);

  localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES);
  localparam logic [3:0] COOL_LOAD = 4'(COOLDOWN_STEPS);

  state_t      state;
  state_t      state_next;
  logic [7:0]  step_cnt;
  logic [3:0]  cool_cnt;
  logic [15:0] lfsr;
  logic        moving;
  logic        roll_hit;
  logic        latch_en;
  logic        cool_load;
  logic        cool_dec;
  logic        step_active;
  logic        unused_lfsr_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .value (lfsr)
  );

  assign unused_lfsr_bits = ^lfsr[15:13];
  assign moving           = is_move(keycode);
  assign roll_hit         = step_pulse && in_grass && ({1'b0, lfsr[7:0]} < ENCOUNTER_THRESH);
  assign step_active      = (state == WALK) || (state == COOLDOWN);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // display_control is tested before step_pulse so a screen change always wins.
  always_comb begin
    state_next = state;
    latch_en   = 1'b0;
    cool_load  = 1'b0;
    cool_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (display_control == DC_MAP) state_next = WALK;
      end
      WALK: begin
        if (display_control == DC_BATTLE) begin
          state_next = IN_BATTLE;
          latch_en   = 1'b1;
        end else if (display_control != DC_MAP) begin
          state_next = IDLE;
        end else if (roll_hit) begin
          state_next = REQUEST;
          latch_en   = 1'b1;
        end
      end
      REQUEST: begin
        if (display_control == DC_BATTLE) state_next = IN_BATTLE;
        else if (display_control != DC_MAP) state_next = IDLE;
      end
      IN_BATTLE: begin
        if (display_control == DC_MAP) begin
          state_next = COOLDOWN;
          cool_load  = 1'b1;
        end else if (display_control != DC_BATTLE) begin
          state_next = IDLE;
        end
      end
      COOLDOWN: begin
        if (display_control == DC_BATTLE) begin
          state_next = IN_BATTLE;
          latch_en   = 1'b1;
        end else if (display_control != DC_MAP) begin
          state_next = IDLE;
        end else if (cool_cnt == 4'd0) begin
          state_next = WALK;
        end else if (step_pulse) begin
          cool_dec = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      step_cnt   <= 8'd0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (!step_active || (state_next != state) || !moving) begin
        step_cnt <= 8'd0;
      end else if (frame_tick) begin
        if (step_cnt + 8'd1 == STEP_LAST) begin
          step_cnt   <= 8'd0;
          step_pulse <= 1'b1;
        end else begin
          step_cnt <= step_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cool_cnt <= 4'd0;
    end else if (cool_load) begin
      cool_cnt <= COOL_LOAD;
    end else if (cool_dec) begin
      cool_cnt <= cool_cnt - 4'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wild_species <= 2'd0;
      wild_level   <= 5'd2;
      battle_start <= 1'b0;
    end else begin
      if (latch_en) begin
        wild_species <= map_species(lfsr[9:8]);
        wild_level   <= 5'd2 + {2'b00, lfsr[12:10]};
      end
      battle_start <= (state_next == REQUEST);
    end
  end

endmodule

// File: tb/tb_encounter_gen.sv
// Bench for encounter_gen: three instances (always / never / default odds) driven
// by shared stimulus, checked against directed expectations and a reference model.
module tb_encounter_gen;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic [7:0] keycode;
  logic       in_grass;
  logic [1:0] dc;

  logic       a_bs, b_bs, c_bs;
  logic [1:0] a_sp, b_sp, c_sp;
  logic [4:0] a_lv, b_lv, c_lv;
  logic       a_pulse, b_pulse, c_pulse;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  encounter_gen #(.ENCOUNTER_THRESH(9'd256), .COOLDOWN_STEPS(4)) dut_a (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .in_grass(in_grass), .display_control(dc), .battle_start(a_bs),
    .wild_species(a_sp), .wild_level(a_lv), .step_pulse(a_pulse));

  encounter_gen #(.ENCOUNTER_THRESH(9'd0)) dut_b (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .in_grass(in_grass), .display_control(dc), .battle_start(b_bs),
    .wild_species(b_sp), .wild_level(b_lv), .step_pulse(b_pulse));

  encounter_gen dut_c (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .in_grass(in_grass), .display_control(dc), .battle_start(c_bs),
    .wild_species(c_sp), .wild_level(c_lv), .step_pulse(c_pulse));

  // Reference model for the default-parameter instance, advanced once per clock.
  localparam int M_STEP   = 8;
  localparam int M_THRESH = 24;
  localparam int M_COOL   = 4;
  localparam int OFF = 0, ON_MAP = 1, WAITING = 2, FIGHTING = 3, RESTING = 4;

  int          m_mode, m_frames, m_cool;
  logic        m_pulse, m_bs;
  logic [1:0]  m_sp;
  logic [4:0]  m_lv;
  logic [15:0] m_lfsr;

  function automatic logic [1:0] spec_species(input logic [15:0] l);
    logic [1:0] s;
    s = l[9:8];
    return (s == 2'd3) ? 2'd0 : s;
  endfunction

  function automatic logic [4:0] spec_level(input logic [15:0] l);
    return 5'(2 + int'(l[12:10]));
  endfunction

  always @(posedge Clk) begin
    int  nxt;
    bit  mv, grab, np;
    if (Reset) begin
      m_mode = OFF; m_frames = 0; m_cool = 0; m_pulse = 0; m_bs = 0;
      m_sp = 2'd0; m_lv = 5'd2; m_lfsr = 16'hACE1;
    end else begin
      mv   = (keycode == 8'h1A) || (keycode == 8'h04) || (keycode == 8'h16) || (keycode == 8'h07);
      nxt  = m_mode;
      grab = 0;
      np   = 0;
      if (m_mode == OFF) begin
        if (dc == 2'b10) nxt = ON_MAP;
      end else if (m_mode == ON_MAP) begin
        if (dc == 2'b11) begin nxt = FIGHTING; grab = 1; end
        else if (dc != 2'b10) nxt = OFF;
        else if (m_pulse && in_grass && int'(m_lfsr[7:0]) < M_THRESH) begin nxt = WAITING; grab = 1; end
      end else if (m_mode == WAITING) begin
        if (dc == 2'b11) nxt = FIGHTING;
        else if (dc != 2'b10) nxt = OFF;
      end else if (m_mode == FIGHTING) begin
        if (dc == 2'b10) begin nxt = RESTING; m_cool = M_COOL; end
        else if (dc != 2'b11) nxt = OFF;
      end else begin
        if (dc == 2'b11) begin nxt = FIGHTING; grab = 1; end
        else if (dc != 2'b10) nxt = OFF;
        else if (m_cool == 0) nxt = ON_MAP;
        else if (m_pulse) m_cool = m_cool - 1;
      end
      if ((m_mode == ON_MAP || m_mode == RESTING) && nxt == m_mode && mv) begin
        if (frame_tick) begin
          if (m_frames + 1 == M_STEP) begin m_frames = 0; np = 1; end
          else m_frames = m_frames + 1;
        end
      end else begin
        m_frames = 0;
      end
      if (grab) begin
        m_sp = spec_species(m_lfsr);
        m_lv = spec_level(m_lfsr);
      end
      m_lfsr  = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      m_bs    = (nxt == WAITING);
      m_mode  = nxt;
      m_pulse = np;
    end
  end

  int         cnt_pulse_a, cnt_pulse_b, late_pulse_a, cnt_bs_a, cnt_bs_b;
  logic       last_first_a;
  logic [1:0] g_sp;
  logic [4:0] g_lv;

  task automatic clear_counts();
    cnt_pulse_a = 0; cnt_pulse_b = 0; late_pulse_a = 0; cnt_bs_a = 0; cnt_bs_b = 0;
  endtask

  task automatic tick_window(input int gap);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick   = 1'b0;
    last_first_a = a_pulse;
    cnt_pulse_a += int'(a_pulse); cnt_pulse_b += int'(b_pulse);
    cnt_bs_a    += int'(a_bs);    cnt_bs_b    += int'(b_bs);
    for (int j = 1; j < gap; j++) begin
      @(negedge Clk);
      late_pulse_a += int'(a_pulse);
      cnt_pulse_a += int'(a_pulse); cnt_pulse_b += int'(b_pulse);
      cnt_bs_a    += int'(a_bs);    cnt_bs_b    += int'(b_bs);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; frame_tick = 1'b0; keycode = 8'h00; in_grass = 1'b0; dc = 2'b00;
    @(negedge Clk); @(negedge Clk);
    total++; if (a_bs !== 1'b0) begin bad++; $display("FAIL reset_battle_start got=%0d want=0", a_bs); end
    total++; if (a_sp !== 2'd0) begin bad++; $display("FAIL reset_species got=%0d want=0", a_sp); end
    total++; if (a_lv !== 5'd2) begin bad++; $display("FAIL reset_level got=%0d want=2", a_lv); end
    total++; if (a_pulse !== 1'b0) begin bad++; $display("FAIL reset_step_pulse got=%0d want=0", a_pulse); end
    total++; if (dut_a.u_lfsr.value !== 16'hACE1) begin bad++; $display("FAIL reset_lfsr got=%h want=ace1", dut_a.u_lfsr.value); end
    total++; if (c_lv !== 5'd2) begin bad++; $display("FAIL reset_level_c got=%0d want=2", c_lv); end
    Reset = 1'b0;
  endtask

  task automatic test_walk();
    int miss;
    dc = 2'b10; keycode = 8'h1A; in_grass = 1'b0;
    repeat (3) @(negedge Clk);
    clear_counts();
    miss = 0;
    for (int k = 1; k <= 16; k++) begin
      tick_window(4);
      if (last_first_a !== ((k % 8) == 0)) miss++;
    end
    total++; if (miss != 0 || late_pulse_a != 0) begin bad++; $display("FAIL walk_pulse_timing got_misplaced=%0d late=%0d want=0", miss, late_pulse_a); end
    total++; if (cnt_pulse_a != 2) begin bad++; $display("FAIL walk_pulse_count got=%0d want=2", cnt_pulse_a); end
    clear_counts();
    repeat (4) tick_window(4);
    keycode = 8'h00;
    tick_window(4);
    keycode = 8'h1A;
    repeat (7) tick_window(4);
    total++; if (cnt_pulse_a != 0) begin bad++; $display("FAIL walk_release_clears got=%0d want=0", cnt_pulse_a); end
    tick_window(4);
    total++; if (last_first_a !== 1'b1) begin bad++; $display("FAIL walk_after_repress got=%0d want=1", last_first_a); end
  endtask

  task automatic test_guaranteed();
    bit found;
    int drop, drift;
    logic [1:0] e_sp;
    logic [4:0] e_lv;
    in_grass = 1'b1; found = 0; e_sp = 2'd0; e_lv = 5'd2;
    for (int i = 0; i < 200 && !found; i++) begin
      frame_tick = ((i % 4) == 0);
      @(negedge Clk);
      if (a_pulse) begin found = 1; e_sp = spec_species(m_lfsr); e_lv = spec_level(m_lfsr); end
    end
    frame_tick = 1'b0;
    total++; if (!found) begin bad++; $display("FAIL guaranteed_step got=none want=step_pulse"); end
    @(negedge Clk);
    total++; if (a_bs !== 1'b1) begin bad++; $display("FAIL guaranteed_bs got=%0d want=1", a_bs); end
    total++; if (a_sp !== e_sp || a_lv !== e_lv) begin bad++; $display("FAIL guaranteed_latch got=%0d/%0d want=%0d/%0d", a_sp, a_lv, e_sp, e_lv); end
    drop = 0; drift = 0;
    for (int i = 0; i < 100; i++) begin
      frame_tick = ((i % 4) == 0);
      @(negedge Clk);
      if (a_bs !== 1'b1) drop++;
      if (a_sp !== e_sp || a_lv !== e_lv) drift++;
    end
    frame_tick = 1'b0;
    total++; if (drop != 0 || drift != 0) begin bad++; $display("FAIL guaranteed_hold got_drops=%0d drift=%0d want=0", drop, drift); end
    dc = 2'b11;
    @(negedge Clk);
    total++; if (a_bs !== 1'b0) begin bad++; $display("FAIL guaranteed_ack_drop got=%0d want=0", a_bs); end
    repeat (3) @(negedge Clk);
    total++; if (a_sp !== e_sp || a_lv !== e_lv) begin bad++; $display("FAIL battle_latch_stable got=%0d/%0d want=%0d/%0d", a_sp, a_lv, e_sp, e_lv); end
  endtask

  task automatic test_cooldown();
    int pulses, last_i;
    bit seen;
    dc = 2'b10; pulses = 0; last_i = -10; seen = 0; g_sp = 2'd0; g_lv = 5'd2;
    for (int i = 0; i < 600 && !seen; i++) begin
      frame_tick = ((i % 4) == 1);
      @(negedge Clk);
      if (a_bs) begin
        seen = 1;
        total++; if (pulses != 5) begin bad++; $display("FAIL cooldown_steps_before_bs got=%0d want=5", pulses); end
        total++; if (i != last_i + 1) begin bad++; $display("FAIL cooldown_bs_latency got=%0d want=1", i - last_i); end
        total++; if (a_sp !== g_sp || a_lv !== g_lv) begin bad++; $display("FAIL cooldown_latch got=%0d/%0d want=%0d/%0d", a_sp, a_lv, g_sp, g_lv); end
      end else if (a_pulse) begin
        pulses++; last_i = i;
        g_sp = spec_species(m_lfsr); g_lv = spec_level(m_lfsr);
      end
    end
    frame_tick = 1'b0;
    total++; if (!seen) begin bad++; $display("FAIL cooldown_bs got=never want=after_step5"); end
  endtask

  task automatic test_abort();
    dc = 2'b00;
    @(negedge Clk);
    total++; if (a_bs !== 1'b0) begin bad++; $display("FAIL abort_drop got=%0d want=0", a_bs); end
    total++; if (a_sp !== g_sp || a_lv !== g_lv) begin bad++; $display("FAIL abort_latch_kept got=%0d/%0d want=%0d/%0d", a_sp, a_lv, g_sp, g_lv); end
    clear_counts();
    repeat (10) tick_window(4);
    total++; if (cnt_pulse_a != 0 || cnt_bs_a != 0) begin bad++; $display("FAIL abort_idle got_pulses=%0d bs=%0d want=0", cnt_pulse_a, cnt_bs_a); end
  endtask

  task automatic test_forced();
    logic [1:0] e_sp;
    logic [4:0] e_lv;
    dc = 2'b10; keycode = 8'h00; in_grass = 1'b0;
    repeat (3) @(negedge Clk);
    dc = 2'b11;
    e_sp = spec_species(m_lfsr); e_lv = spec_level(m_lfsr);
    @(negedge Clk);
    total++; if (a_bs !== 1'b0) begin bad++; $display("FAIL forced_no_bs got=%0d want=0", a_bs); end
    total++; if (a_sp !== e_sp || a_lv !== e_lv) begin bad++; $display("FAIL forced_latch_a got=%0d/%0d want=%0d/%0d", a_sp, a_lv, e_sp, e_lv); end
    total++; if (b_sp !== e_sp || b_lv !== e_lv) begin bad++; $display("FAIL forced_latch_b got=%0d/%0d want=%0d/%0d", b_sp, b_lv, e_sp, e_lv); end
  endtask

  task automatic test_reset_mid_request();
    bit seen;
    dc = 2'b00;
    repeat (2) @(negedge Clk);
    dc = 2'b10; keycode = 8'h16; in_grass = 1'b1; seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      frame_tick = ((i % 4) == 0);
      @(negedge Clk);
      if (a_bs) seen = 1;
    end
    frame_tick = 1'b0;
    total++; if (!seen) begin bad++; $display("FAIL midreq_reach got=no_request want=request"); end
    Reset = 1'b1;
    @(negedge Clk);
    total++; if (a_bs !== 1'b0 || a_lv !== 5'd2 || a_sp !== 2'd0) begin bad++; $display("FAIL midreq_reset got=%0d/%0d/%0d want=0/0/2", a_bs, a_sp, a_lv); end
    Reset = 1'b0;
  endtask

  task automatic test_never_offgrass();
    dc = 2'b10; keycode = 8'h07; in_grass = 1'b0;
    repeat (2) @(negedge Clk);
    clear_counts();
    repeat (80) tick_window(2);
    total++; if (cnt_pulse_a != 10) begin bad++; $display("FAIL offgrass_steps got=%0d want=10", cnt_pulse_a); end
    total++; if (cnt_bs_a != 0) begin bad++; $display("FAIL offgrass_bs got=%0d want=0", cnt_bs_a); end
    in_grass = 1'b1;
    clear_counts();
    repeat (400) tick_window(2);
    total++; if (cnt_pulse_b != 50) begin bad++; $display("FAIL never_steps got=%0d want=50", cnt_pulse_b); end
    total++; if (cnt_bs_b != 0) begin bad++; $display("FAIL never_bs got=%0d want=0", cnt_bs_b); end
  endtask

  task automatic test_random();
    int r, hits;
    logic prev_bs;
    Reset = 1'b1; frame_tick = 1'b0;
    @(negedge Clk);
    Reset = 1'b0; dc = 2'b10; keycode = 8'h1A; in_grass = 1'b1;
    hits = 0; prev_bs = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        r = $urandom_range(0, 19);
        dc = (r < 11) ? 2'b10 : (r < 17) ? 2'b11 : (r < 19) ? 2'b00 : 2'b01;
      end
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 9);
        keycode = (r < 2) ? 8'h1A : (r < 4) ? 8'h04 : (r < 6) ? 8'h16 : (r < 8) ? 8'h07 :
                  (r == 8) ? 8'h00 : 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 199) == 0) in_grass = ~in_grass;
      frame_tick = ($urandom_range(0, 2) == 0);
      @(negedge Clk);
      if (m_bs && !prev_bs) hits++;
      prev_bs = m_bs;
      total++; if (c_bs !== m_bs) begin bad++; $display("FAIL rand_bs cyc=%0d got=%0d want=%0d", i, c_bs, m_bs); end
      total++; if (c_pulse !== m_pulse) begin bad++; $display("FAIL rand_pulse cyc=%0d got=%0d want=%0d", i, c_pulse, m_pulse); end
      total++; if (c_sp !== m_sp) begin bad++; $display("FAIL rand_species cyc=%0d got=%0d want=%0d", i, c_sp, m_sp); end
      total++; if (c_lv !== m_lv) begin bad++; $display("FAIL rand_level cyc=%0d got=%0d want=%0d", i, c_lv, m_lv); end
    end
    frame_tick = 1'b0;
    $display("random phase: %0d encounter requests seen", hits);
  endtask

  initial begin
    test_reset();
    test_walk();
    test_guaranteed();
    test_cooldown();
    test_abort();
    test_forced();
    test_reset_mid_request();
    test_never_offgrass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
